mem_dcache_fill: RTL
====================

# mem_dcache_fill

Line-fill engine directly upstream of the write-back data cache on the `mem_clk` side. It accepts one line-miss request at a time and issues DRAM-width read bursts. It assembles the returned beats into a full cache line, then drives the cache fill port (`fill_rddirty` pulse, stable address, `fill_we` pulse) with the fixed spacing the cache's dirty-eviction pipeline needs. It owns all fill sequencing so the cache sees only complete, aligned lines.

## Interface
- LOG2CACHELINESIZE, 9, log2 of line width in bits
- LOG2DRAMWIDTHBITS, 7, log2 of DRAM beat width in bits; must be ≤ LOG2CACHELINESIZE
- FILL_WE_DELAY, 3, cycles from `fill_rddirty` pulse to `fill_we` pulse; ≥1

Ports:
- mem_clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  miss request
- req_addr  in  32  any byte address in the missing line
- req_ready  out  1  engine idle, request accepted when both high
- dram_address  out  32  beat read address
- dram_rd  out  1  beat read request
- dram_wait  in  1  DRAM not accepting; request held
- dram_readdata  in  2^LOG2DRAMWIDTHBITS  returned beat
- dram_readvalid  in  1  beat valid
- fill_addr  out  32  line-aligned fill address
- fill_data  out  2^LOG2CACHELINESIZE  assembled line
- fill_rddirty  out  1  one-cycle pulse: victim dirty lookup
- fill_we  out  1  one-cycle pulse: write line into cache
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when a demand fill's `fill_we` fires

## Operation
- BEATS = 2^(LOG2CACHELINESIZE−LOG2DRAMWIDTHBITS); BEAT_BYTES = 2^(LOG2DRAMWIDTHBITS−3).
- Line base = req_addr with low LOG2CACHELINESIZE−3 bits zeroed; latched on acceptance.
- States: IDLE → ISSUE → COLLECT → DIRTY → HOLD → WRITE → IDLE.
- IDLE: req_ready=1. On req_valid, latch base, clear issue/receive counters, go ISSUE.
- ISSUE: dram_rd=1, dram_address = base + issued×BEAT_BYTES. The counter advances only when dram_wait=0. After BEATS accepted, go COLLECT; if the final beat has already arrived, go directly to DIRTY.
- Beats are returned in order. Receive counter k places beat into fill_data[k×DRAMW +: DRAMW]. Beats are collected in ISSUE and COLLECT; they are ignored in all other states, including IDLE strays.
- COLLECT: on the BEATS-th beat, go DIRTY.
- DIRTY: fill_rddirty=1 for one cycle; go HOLD.
- HOLD: FILL_WE_DELAY−1 cycles, then WRITE.
- WRITE: fill_we=1 for one cycle, done=1 if demand fill; go IDLE.
- fill_addr = base from DIRTY through WRITE inclusive; fill_data stable from DIRTY through WRITE.
- Counters are log2(BEATS)+1 bits wide; address adds wrap modulo 2^32.

## Timing
- Reset values: req_ready=0 during reset, 1 the first cycle after; dram_rd, fill_rddirty, fill_we, busy, done=0; dram_address, fill_addr, fill_data=0.
- Minimum latency with dram_wait=0 and readvalid one cycle after each request: accept at T; `fill_we` at T+BEATS+2+FILL_WE_DELAY.
- req_valid while busy: ignored, req_ready=0; requester holds.
- dram_wait high: dram_rd and dram_address held unchanged.
- Reset mid-fill: immediate return to IDLE. The partial line is discarded, and no fill_we is issued for it.
- BEATS=1: ISSUE issues one read; all rules are otherwise unchanged.

## Configuration
- MEM_DCACHE_FILL_PREFETCH_EN defined: after a demand WRITE, if req_valid=0 that cycle, start a fill of base + line bytes (sequential prefetch, wraps at 2^32).
  - A prefetch fill never pulses done, and no prefetch chains further.
  - req_ready stays 0 until the prefetch WRITE completes.
- Undefined: WRITE always returns to IDLE; no prefetch logic is synthesized.

## Structure
- Shared package mem_fill_pkg: state enum, BEATS/BEAT_BYTES derivation functions, line-alignment mask function.
- Sub-module mem_fill_linebuf: beat-assembly register with receive counter, clear, and full flag.

## Test plan
- Defaults, req_addr=0x0000_1234, dram_wait=0, beats 0xA..,0xB..,0xC..,0xD.. → dram_address 0x1200,0x1210,0x1220,0x1230; fill_addr=0x1200; line = {D,C,B,A}; fill_we exactly 3 cycles after fill_rddirty; done pulses once.
- dram_wait high 5 cycles on beat 2 → dram_address held at 0x1220, no duplicate request, line content correct.
- req_valid held during a fill → req_ready=0 until the cycle after WRITE; second request accepted once, with no lost or duplicate fill.
- resetn low after 2 beats, then late readvalid beats → no fill_we, stray beats ignored, next request fills correctly.
- Request at 0xFFFF_FFC0 with prefetch enabled → demand fill 0xFFFF_FFC0 with done, then prefetch fill 0x0000_0000 without done.
- LOG2CACHELINESIZE=LOG2DRAMWIDTHBITS=7 → single read, fill_data equals the beat.

Source files
------------

// File: rtl/mem_fill_pkg.sv
// Shared types and size helpers for the data-cache line-fill engine.
package mem_fill_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_DIRTY   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_WRITE   = 3'd5
    } fill_state_e;

    // Number of DRAM beats that make up one cache line.
    function automatic int unsigned fill_beats(input int unsigned l2_line, input int unsigned l2_dram);
        return 32'd1 << (l2_line - l2_dram);
    endfunction

    // Bytes carried by one DRAM beat.
    function automatic int unsigned fill_beat_bytes(input int unsigned l2_dram);
        return 32'd1 << (l2_dram - 32'd3);
    endfunction

    // Bytes in one cache line.
    function automatic int unsigned fill_line_bytes(input int unsigned l2_line);
        return 32'd1 << (l2_line - 32'd3);
    endfunction

    // Mask that clears the byte offset within a line.
    function automatic logic [31:0] fill_line_mask(input int unsigned l2_line);
        return ~((32'd1 << (l2_line - 32'd3)) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_fill_linebuf.sv
// Beat-assembly buffer: places in-order DRAM beats into a full cache line.
module mem_fill_linebuf
    import mem_fill_pkg::*;
#(
    parameter int unsigned  LOG2CACHELINESIZE = 9,
    parameter int unsigned  LOG2DRAMWIDTHBITS = 7,
    localparam int unsigned LINE_W = 32'd1 << LOG2CACHELINESIZE,
    localparam int unsigned DRAM_W = 32'd1 << LOG2DRAMWIDTHBITS
) (
    input  logic              mem_clk,
    input  logic              resetn,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DRAM_W-1:0] i_data,
    output logic [LINE_W-1:0] o_line,
    output logic              o_full,
    output logic              o_last_c
);

    localparam int unsigned BEATS = fill_beats(LOG2CACHELINESIZE, LOG2DRAMWIDTHBITS);
    localparam int unsigned CNT_W = LOG2CACHELINESIZE - LOG2DRAMWIDTHBITS + 1;

    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_line;
    logic              r_full;
    logic              w_take;

    // Accept a beat only while enabled and the line still has room.
    assign w_take   = i_en && i_valid && (r_cnt < CNT_W'(BEATS));
    assign o_last_c = w_take && (r_cnt == CNT_W'(BEATS - 1));
    assign o_line   = r_line;
    assign o_full   = r_full;

    // Receive counter, line storage and full flag.
    always_ff @(posedge mem_clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt  <= '0;
            r_line <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (w_take) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_full <= o_last_c;
            for (int unsigned i = 0; i < BEATS; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    r_line[i*DRAM_W +: DRAM_W] <= i_data;
                end
            end
        end
    end

endmodule

// File: rtl/mem_dcache_fill.sv
// Line-fill engine for the write-back data cache: bursts a missing line from
// DRAM, assembles it, then drives the cache fill port with fixed spacing.
// Optional sequential prefetch: define MEM_DCACHE_FILL_PREFETCH_EN.
module mem_dcache_fill
    import mem_fill_pkg::*;
#(
    parameter int unsigned  LOG2CACHELINESIZE = 9,
    parameter int unsigned  LOG2DRAMWIDTHBITS = 7,
    parameter int unsigned  FILL_WE_DELAY     = 3,
    localparam int unsigned LINE_W = 32'd1 << LOG2CACHELINESIZE,
    localparam int unsigned DRAM_W = 32'd1 << LOG2DRAMWIDTHBITS
) (
    input  logic              mem_clk,
    input  logic              resetn,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    output logic [31:0]       dram_address,
    output logic              dram_rd,
    input  logic              dram_wait,
    input  logic [DRAM_W-1:0] dram_readdata,
    input  logic              dram_readvalid,
    output logic [31:0]       fill_addr,
    output logic [LINE_W-1:0] fill_data,
    output logic              fill_rddirty,
    output logic              fill_we,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BEATS      = fill_beats(LOG2CACHELINESIZE, LOG2DRAMWIDTHBITS);
    localparam int unsigned BEAT_BYTES = fill_beat_bytes(LOG2DRAMWIDTHBITS);
    localparam int unsigned LINE_BYTES = fill_line_bytes(LOG2CACHELINESIZE);
    localparam logic [31:0] LINE_MASK  = fill_line_mask(LOG2CACHELINESIZE);
    localparam int unsigned CNT_W      = LOG2CACHELINESIZE - LOG2DRAMWIDTHBITS + 1;
    localparam int unsigned HOLD_W     = (FILL_WE_DELAY > 2) ? $clog2(FILL_WE_DELAY) : 1;
    localparam int unsigned HOLD_LAST  = (FILL_WE_DELAY >= 2) ? FILL_WE_DELAY - 2 : 0;

    fill_state_e       r_state, w_state_nxt;
    logic [31:0]       r_base, w_base_nxt;
    logic [31:0]       r_addr, w_addr_nxt;
    logic [CNT_W-1:0]  r_issued, w_issued_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic              w_lb_clear, w_lb_en, w_lb_full, w_lb_last_c;
    logic              w_done_nxt;
    logic              r_req_ready, r_dram_rd, r_rddirty, r_we, r_busy, r_done;
`ifdef MEM_DCACHE_FILL_PREFETCH_EN
    logic              r_pf, w_pf_nxt;
`endif

    assign req_ready    = r_req_ready;
    assign dram_address = r_addr;
    assign dram_rd      = r_dram_rd;
    assign fill_addr    = r_base;
    assign fill_rddirty = r_rddirty;
    assign fill_we      = r_we;
    assign busy         = r_busy;
    assign done         = r_done;

    // Beats are only captured while reads are outstanding.
    assign w_lb_en = (r_state == ST_ISSUE) || (r_state == ST_COLLECT);

    mem_fill_linebuf #(
        .LOG2CACHELINESIZE (LOG2CACHELINESIZE),
        .LOG2DRAMWIDTHBITS (LOG2DRAMWIDTHBITS)
    ) u_linebuf (
        .mem_clk  (mem_clk),
        .resetn   (resetn),
        .i_clear  (w_lb_clear),
        .i_en     (w_lb_en),
        .i_valid  (dram_readvalid),
        .i_data   (dram_readdata),
        .o_line   (fill_data),
        .o_full   (w_lb_full),
        .o_last_c (w_lb_last_c)
    );

    // Next-state and next-datapath decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_base_nxt   = r_base;
        w_addr_nxt   = r_addr;
        w_issued_nxt = r_issued;
        w_hold_nxt   = r_hold;
        w_lb_clear   = 1'b0;
`ifdef MEM_DCACHE_FILL_PREFETCH_EN
        w_pf_nxt     = r_pf;
`endif
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_base_nxt   = req_addr & LINE_MASK;
                    w_addr_nxt   = req_addr & LINE_MASK;
                    w_issued_nxt = '0;
                    w_lb_clear   = 1'b1;
                    w_state_nxt  = ST_ISSUE;
`ifdef MEM_DCACHE_FILL_PREFETCH_EN
                    w_pf_nxt     = 1'b0;
`endif
                end
            end
            ST_ISSUE: begin
                if (!dram_wait) begin
                    w_issued_nxt = r_issued + CNT_W'(1);
                    if (r_issued == CNT_W'(BEATS - 1)) begin
                        w_state_nxt = (w_lb_full || w_lb_last_c) ? ST_DIRTY : ST_COLLECT;
                    end else begin
                        w_addr_nxt = r_addr + 32'(BEAT_BYTES);
                    end
                end
            end
            ST_COLLECT: begin
                if (w_lb_full || w_lb_last_c) begin
                    w_state_nxt = ST_DIRTY;
                end
            end
            ST_DIRTY: begin
                w_hold_nxt  = '0;
                w_state_nxt = (FILL_WE_DELAY > 1) ? ST_HOLD : ST_WRITE;
            end
            ST_HOLD: begin
                if (r_hold == HOLD_W'(HOLD_LAST)) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_IDLE;
`ifdef MEM_DCACHE_FILL_PREFETCH_EN
                // Quiet requester after a demand fill: fetch the next line.
                if (!r_pf && !req_valid) begin
                    w_base_nxt   = r_base + 32'(LINE_BYTES);
                    w_addr_nxt   = r_base + 32'(LINE_BYTES);
                    w_issued_nxt = '0;
                    w_lb_clear   = 1'b1;
                    w_pf_nxt     = 1'b1;
                    w_state_nxt  = ST_ISSUE;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
`ifdef MEM_DCACHE_FILL_PREFETCH_EN
        w_done_nxt = (w_state_nxt == ST_WRITE) && !w_pf_nxt;
`else
        w_done_nxt = (w_state_nxt == ST_WRITE);
`endif
    end

    // State, datapath and registered outputs.
    always_ff @(posedge mem_clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_addr      <= '0;
            r_issued    <= '0;
            r_hold      <= '0;
            r_req_ready <= 1'b0;
            r_dram_rd   <= 1'b0;
            r_rddirty   <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_base      <= w_base_nxt;
            r_addr      <= w_addr_nxt;
            r_issued    <= w_issued_nxt;
            r_hold      <= w_hold_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_dram_rd   <= (w_state_nxt == ST_ISSUE);
            r_rddirty   <= (w_state_nxt == ST_DIRTY);
            r_we        <= (w_state_nxt == ST_WRITE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
        end
    end

`ifdef MEM_DCACHE_FILL_PREFETCH_EN
    // Marks the fill in flight as a prefetch.
    always_ff @(posedge mem_clk or negedge resetn) begin
        if (!resetn) begin
            r_pf <= 1'b0;
        end else begin
            r_pf <= w_pf_nxt;
        end
    end
`endif

endmodule
